// File: rtl/round_engine_pkg.sv
// Shared encodings for the typing-game round engine: game states from the
// controller, engine FSM states and common constants.
package round_engine_pkg;

  typedef enum logic [1:0] {
    GS_SELECT    = 2'd0,
    GS_COUNTDOWN = 2'd1,
    GS_INGAME    = 2'd2,
    GS_FINISH    = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT_KEY = 2'd2,
    ST_DONE     = 2'd3
  } eng_state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [6:0] CNT_MAX     = 7'd127;

  // Decrement that stops at zero.
  function automatic logic [6:0] dec_floor0(input logic [6:0] v);
    return (v == 7'd0) ? 7'd0 : v - 7'd1;
  endfunction

endpackage

// File: rtl/round_engine_sat_counter7.sv
// 7-bit saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter7
  import round_engine_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [6:0] count
);

  logic [6:0] count_d;
  logic [6:0] count_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 7'd0;
    end else if (en && (count_q != CNT_MAX)) begin
      count_d = count_q + 7'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 7'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/round_engine.sv
// Gameplay sequencer: fetches target characters from the word ROM, checks
// keystrokes, counts words and errors and ends the round on its limit.
module round_engine
  import round_engine_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        state,
  input  logic              Mode,
  input  logic [6:0]        value,
  input  logic              tick_1hz,
  input  logic              key_valid,
  input  logic [7:0]        key_ascii,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              finish,
  output logic [6:0]        remaining,
  output logic [6:0]        words_done,
  output logic [6:0]        errors,
  output logic              err_pulse,
  output logic [7:0]        expected
);

  eng_state_e        fsm_d, fsm_q;
  logic [6:0]        remaining_d, remaining_q;
  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
  logic [7:0]        expected_d, expected_q;
  logic              err_pulse_d, err_pulse_q;
  logic              finish_d, finish_q;
  logic              cnt_clr_s;
  logic              word_inc_s;
  logic              err_inc_s;
  logic              in_game_s;
  logic              key_hit_s;
  logic              dec_s;

  assign in_game_s = (state == GS_INGAME);
  assign key_hit_s = key_valid && (key_ascii == expected_q);

  // Next-state, counter control and registered-output computation.
  always_comb begin
    fsm_d       = fsm_q;
    remaining_d = remaining_q;
    rom_addr_d  = rom_addr_q;
    expected_d  = expected_q;
    err_pulse_d = 1'b0;
    cnt_clr_s   = 1'b0;
    word_inc_s  = 1'b0;
    err_inc_s   = 1'b0;
    dec_s       = 1'b0;

    case (fsm_q)
      ST_IDLE: begin
        if (in_game_s) begin
          remaining_d = value;
          rom_addr_d  = '0;
          cnt_clr_s   = 1'b1;
          fsm_d       = ST_FETCH;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Abort beats termination; keystrokes here are dropped on purpose.
        if (!in_game_s) begin
          fsm_d = ST_IDLE;
        end else if (remaining_q == 7'd0) begin
          fsm_d = ST_DONE;
        end else begin
          expected_d = rom_data;
          dec_s      = !Mode && tick_1hz;
          fsm_d      = ST_WAIT_KEY;
        end
      end
      ST_WAIT_KEY: begin
        if (!in_game_s) begin
          fsm_d = ST_IDLE;
        end else if (remaining_q == 7'd0) begin
          fsm_d = ST_DONE;
        end else if (key_hit_s) begin
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          word_inc_s = (expected_q == ASCII_SPACE);
          // Modes are exclusive, so at most one decrement source fires.
          dec_s      = Mode ? (expected_q == ASCII_SPACE) : tick_1hz;
          fsm_d      = ST_FETCH;
        end else if (key_valid) begin
          err_inc_s   = 1'b1;
          err_pulse_d = 1'b1;
          dec_s       = !Mode && tick_1hz;
          fsm_d       = ST_WAIT_KEY;
        end else begin
          dec_s = !Mode && tick_1hz;
          fsm_d = ST_WAIT_KEY;
        end
      end
      ST_DONE: begin
        if (state == GS_SELECT) begin
          fsm_d = ST_IDLE;
        end else begin
          fsm_d = ST_DONE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    if (dec_s) begin
      remaining_d = dec_floor0(remaining_q);
    end else begin
      remaining_d = remaining_d;
    end

    finish_d = (fsm_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      remaining_q <= 7'd0;
      rom_addr_q  <= '0;
      expected_q  <= 8'h00;
      err_pulse_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      remaining_q <= remaining_d;
      rom_addr_q  <= rom_addr_d;
      expected_q  <= expected_d;
      err_pulse_q <= err_pulse_d;
      finish_q    <= finish_d;
    end
  end

  sat_counter7 u_words (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .en    (word_inc_s),
    .count (words_done)
  );

  sat_counter7 u_errors (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .en    (err_inc_s),
    .count (errors)
  );

  assign rom_addr  = rom_addr_q;
  assign remaining = remaining_q;
  assign expected  = expected_q;
  assign err_pulse = err_pulse_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_round_engine.sv
// Self-checking bench for round_engine: vector table, directed corner cases
// and a randomized run against a keystroke-level reference model.
module tb_round_engine;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        state;
  logic              Mode;
  logic [6:0]        value;
  logic              tick_1hz;
  logic              key_valid;
  logic [7:0]        key_ascii;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              finish;
  logic [6:0]        remaining;
  logic [6:0]        words_done;
  logic [6:0]        errors;
  logic              err_pulse;
  logic [7:0]        expected;

  logic [7:0] rom_mem [0:DEPTH-1];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] key;
    int         addr;
    int         words;
    int         errs;
    int         rem;
  } vec_t;

  vec_t tbl [9];

  round_engine #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .Mode       (Mode),
    .value      (value),
    .tick_1hz   (tick_1hz),
    .key_valid  (key_valid),
    .key_ascii  (key_ascii),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .finish     (finish),
    .remaining  (remaining),
    .words_done (words_done),
    .errors     (errors),
    .err_pulse  (err_pulse),
    .expected   (expected)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    key_valid = 1'b1;
    key_ascii = k;
    cyc();
    key_valid = 1'b0;
    cyc();
  endtask

  task automatic start_round(input logic m, input logic [6:0] v);
    state = 2'd0;
    cyc();
    cyc();
    Mode  = m;
    value = v;
    state = 2'd2;
    cyc();
    cyc();
  endtask

  task automatic fill_ab();
    for (int i = 0; i < DEPTH; i++) begin
      rom_mem[i] = (i % 3 == 0) ? 8'h61 : ((i % 3 == 1) ? 8'h62 : 8'h20);
    end
  endtask

  // Randomized round checked against a keystroke-level model of the game.
  task automatic random_round(input logic m, input int v);
    int   pos;
    int   rem;
    int   w;
    int   e;
    bit   done_m;
    bit   do_key;
    bit   do_tick;
    logic [7:0] k;
    pos    = 0;
    rem    = v;
    w      = 0;
    e      = 0;
    done_m = 1'b0;
    start_round(m, 7'(v));
    for (int n = 0; n < 150 && !done_m; n++) begin
      do_key  = ($urandom_range(0, 9) < 8);
      do_tick = !m && ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 9) < 7) k = rom_mem[pos];
      else if ($urandom_range(0, 5) == 0) k = 8'h20;
      else k = 8'(8'h61 + $urandom_range(0, 25));
      key_valid = do_key;
      key_ascii = k;
      tick_1hz  = do_tick;
      cyc();
      key_valid = 1'b0;
      tick_1hz  = 1'b0;
      cyc();
      cyc();
      if (do_key) begin
        if (k == rom_mem[pos]) begin
          if (k == 8'h20) begin
            if (w < 127) w++;
            if (m && rem > 0) rem--;
          end
          pos = (pos + 1) % DEPTH;
        end else if (e < 127) begin
          e++;
        end
      end
      if (do_tick && rem > 0) rem--;
      done_m = (rem == 0);
      check("rnd_remaining", remaining, rem);
      check("rnd_words", words_done, w);
      check("rnd_errors", errors, e);
      check("rnd_addr", rom_addr, pos);
      check("rnd_finish", finish, done_m);
      if (!done_m) check("rnd_expected", expected, rom_mem[pos]);
    end
  endtask

  initial begin
    tbl[0] = '{8'h78, 0, 0, 1, 25};
    tbl[1] = '{8'h61, 1, 0, 1, 25};
    tbl[2] = '{8'h62, 2, 0, 1, 25};
    tbl[3] = '{8'h61, 2, 0, 2, 25};
    tbl[4] = '{8'h20, 3, 1, 2, 24};
    tbl[5] = '{8'h20, 3, 1, 3, 24};
    tbl[6] = '{8'h61, 4, 1, 3, 24};
    tbl[7] = '{8'h62, 5, 1, 3, 24};
    tbl[8] = '{8'h20, 6, 2, 3, 23};

    rst       = 1'b1;
    state     = 2'd0;
    Mode      = 1'b0;
    value     = 7'd15;
    tick_1hz  = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    fill_ab();
    cyc();
    check("rst_finish", finish, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_remaining", remaining, 0);
    check("rst_words", words_done, 0);
    check("rst_errors", errors, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_expected", expected, 0);
    rst = 1'b0;
    cyc();

    // Table-driven word-mode round.
    start_round(1'b1, 7'd25);
    check("tbl_first_expected", expected, 8'h61);
    for (int i = 0; i < 9; i++) begin
      press(tbl[i].key);
      check($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].addr);
      check($sformatf("tbl%0d_words", i), words_done, tbl[i].words);
      check($sformatf("tbl%0d_errors", i), errors, tbl[i].errs);
      check($sformatf("tbl%0d_remaining", i), remaining, tbl[i].rem);
    end

    // Word mode: 75 correct keys end the round.
    start_round(1'b1, 7'd25);
    for (int i = 0; i < 74; i++) press(rom_mem[i]);
    check("wm_rem_before", remaining, 1);
    key_valid = 1'b1;
    key_ascii = 8'h20;
    cyc();
    key_valid = 1'b0;
    check("wm_words", words_done, 25);
    check("wm_remaining", remaining, 0);
    check("wm_finish_not_yet", finish, 0);
    cyc();
    check("wm_finish", finish, 1);
    press(8'h61);
    press(8'h78);
    check("wm_frozen_words", words_done, 25);
    check("wm_frozen_errors", errors, 0);
    check("wm_frozen_addr", rom_addr, 75);
    state = 2'd0;
    cyc();
    check("wm_finish_falls", finish, 0);

    // Time mode: 15 ticks, no keys.
    start_round(1'b0, 7'd15);
    for (int i = 1; i <= 15; i++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      check($sformatf("tm_rem_%0d", i), remaining, 15 - i);
    end
    check("tm_finish_not_yet", finish, 0);
    cyc();
    check("tm_finish", finish, 1);
    check("tm_words", words_done, 0);

    // Error handling and err_pulse timing.
    start_round(1'b0, 7'd30);
    key_valid = 1'b1;
    key_ascii = 8'h78;
    cyc();
    key_valid = 1'b0;
    check("err_pulse_high", err_pulse, 1);
    cyc();
    check("err_pulse_low", err_pulse, 0);
    check("err_count", errors, 1);
    check("err_addr_hold", rom_addr, 0);
    press(8'h61);
    check("err_then_ok_addr", rom_addr, 1);

    // Tick to 0 together with a correct space key.
    start_round(1'b0, 7'd15);
    for (int i = 0; i < 14; i++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
    end
    press(8'h61);
    press(8'h62);
    check("sim_rem_one", remaining, 1);
    tick_1hz  = 1'b1;
    key_valid = 1'b1;
    key_ascii = 8'h20;
    cyc();
    tick_1hz  = 1'b0;
    key_valid = 1'b0;
    check("sim_words", words_done, 1);
    check("sim_remaining", remaining, 0);
    cyc();
    check("sim_finish", finish, 1);

    // Abort from WAIT_KEY and re-entry.
    start_round(1'b1, 7'd40);
    press(8'h61);
    press(8'h62);
    press(8'h20);
    state = 2'd0;
    cyc();
    cyc();
    check("abort_finish", finish, 0);
    check("abort_words_hold", words_done, 1);
    check("abort_rem_hold", remaining, 39);
    value = 7'd50;
    state = 2'd2;
    cyc();
    cyc();
    check("reenter_rem", remaining, 50);
    check("reenter_addr", rom_addr, 0);
    check("reenter_words", words_done, 0);
    check("reenter_expected", expected, 8'h61);

    // Error saturation, then asynchronous reset mid-round.
    start_round(1'b0, 7'd60);
    key_valid = 1'b1;
    key_ascii = 8'h78;
    for (int i = 0; i < 130; i++) cyc();
    key_valid = 1'b0;
    cyc();
    check("sat_errors", errors, 127);
    press(8'h61);
    #2;
    rst = 1'b1;
    #1;
    check("arst_finish", finish, 0);
    check("arst_remaining", remaining, 0);
    check("arst_words", words_done, 0);
    check("arst_errors", errors, 0);
    check("arst_addr", rom_addr, 0);
    check("arst_expected", expected, 0);
    check("arst_err_pulse", err_pulse, 0);
    cyc();
    rst = 1'b0;

    // Randomized rounds against the reference model.
    for (int i = 0; i < DEPTH; i++) begin
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(0, 25));
    end
    for (int r = 0; r < 5; r++) begin
      if (r % 2 == 0) random_round(1'b0, $urandom_range(15, 40));
      else random_round(1'b1, $urandom_range(25, 40));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_engine.md
# round_engine

Gameplay sequencer for the typing game. While the top-level game state is INGAME, it fetches target characters from the word ROM, compares each keystroke against the expected character, and counts completed words and errors. It tracks the round limit, which is seconds in time mode or words in word mode, and raises `finish` to end the round. It sits between the game-state controller, the keyboard decoder and the word ROM, and feeds the 7-segment and LED display logic.

## Interface
- `ADDR_W`, 10: word-ROM character address width.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `state` in 2: game state from the controller; SELECT=0, COUNTDOWN=1, INGAME=2, FINISH=3.
- `Mode` in 1: 0 = time mode, 1 = word mode; stable outside SELECT.
- `value` in 7: round limit, either seconds (15..90) or words (25..100).
- `tick_1hz` in 1: one-cycle pulse, once per second.
- `key_valid` in 1: one-cycle strobe for a decoded keystroke.
- `key_ascii` in 8: ASCII of the keystroke; valid with `key_valid`.
- `rom_addr` out ADDR_W: character address to the word ROM.
- `rom_data` in 8: ROM character; valid exactly 1 cycle after `rom_addr` changes. Words are separated by 0x20.
- `finish` out 1: round over; a level signal.
- `remaining` out 7: seconds left, or words left.
- `words_done` out 7: completed words, saturating at 127.
- `errors` out 7: wrong keystrokes, saturating at 127.
- `err_pulse` out 1: one-cycle pulse on each wrong keystroke.
- `expected` out 8: currently expected character, for display.

## Operation
- FSM states: IDLE, FETCH, WAIT_KEY, DONE.
- **IDLE**
  - All counters are held.
  - On `state==INGAME`: load `remaining<=value`, `words_done<=0`, `errors<=0`, `rom_addr<=0`, then go to FETCH.
- **FETCH**
  - Lasts 1 cycle.
  - `expected<=rom_data`, then go to WAIT_KEY.
- **WAIT_KEY**
  - Keystroke with `key_ascii==expected`:
    - `rom_addr<=rom_addr+1`; the address wraps modulo 2^ADDR_W.
    - If `expected==0x20`: `words_done` increments, and in word mode `remaining` decrements.
    - Go to FETCH.
  - Keystroke with a mismatch:
    - `errors` increments (saturating).
    - `err_pulse=1`.
    - Stay in WAIT_KEY; the address does not advance.
  - Keystrokes arriving in FETCH are dropped. They are not counted as errors.
- **Time mode**
  - `tick_1hz` decrements `remaining` in FETCH and in WAIT_KEY.
- **Termination**
  - When `remaining` reaches 0, go to DONE on the following cycle.
  - `remaining` never underflows. A decrement at 0 is ignored.
- **DONE**
  - `finish=1`; all counters are frozen.
  - Go to IDLE on `state==SELECT`.
- **Abort**
  - If `state` leaves INGAME in FETCH or WAIT_KEY without `finish`, go to IDLE. Counters hold their values.
- **Simultaneous events**
  - Tick and a correct keystroke in the same cycle: both take effect.
  - Word completion in word mode at `remaining==1`: `remaining=0` and the FSM goes to DONE. That final word counts.
  - A time-mode tick to 0 in the same cycle as a correct keystroke: the keystroke is counted, then the FSM goes to DONE.

## Timing
- Reset values:
  - FSM = IDLE
  - `finish=0`, `err_pulse=0`
  - `remaining=0`, `words_done=0`, `errors=0`
  - `rom_addr=0`, `expected=0x00`
- From `state` becoming INGAME to `expected` being valid: 2 cycles (IDLE→FETCH, FETCH→WAIT_KEY).
- Correct keystroke → next `expected`: 2 cycles, via FETCH.
- `err_pulse` is asserted in the cycle after `key_valid`, for exactly 1 cycle.
- `finish` rises 1 cycle after `remaining` becomes 0. It falls on the cycle after `state==SELECT` is sampled.
- Reset mid-round: all outputs return to their reset values immediately (asynchronous). `finish` deasserts at once.

## Structure
- Shared package holds:
  - the game-state encodings (SELECT/COUNTDOWN/INGAME/FINISH), which are shared with the controller;
  - the engine-state enum;
  - `ASCII_SPACE=8'h20`;
  - `CNT_MAX=7'd127`.
- Sub-module: `sat_counter7`, a 7-bit saturating up-counter with clear and enable. It is instantiated twice, for `words_done` and `errors`.
- The FSM and the `remaining`/address logic stay in `round_engine`.

## Test plan
- **Word mode, value=25**: ROM holds "ab ab ab …"; type 75 correct keys → `words_done=25`, `remaining=0`, `finish` rises 1 cycle later.
- **Time mode, value=15**: 15 `tick_1hz` pulses, no keys → `remaining` steps 15→0, `finish=1`, `words_done=0`.
- **Error handling**: with `expected='a'`, key 'x' → `err_pulse` for 1 cycle, `errors=1`, `rom_addr` unchanged; then key 'a' → `rom_addr=1`.
- **Simultaneous events**: time mode, `remaining=1`, tick and correct space key in the same cycle → `words_done` increments, `remaining=0`, then DONE.
- **Abort**: `state` goes INGAME→SELECT in WAIT_KEY → FSM returns to IDLE, `finish` stays 0. Re-entering INGAME reloads `remaining=value` and `rom_addr=0`.
- **Saturation and reset**: 130 wrong keys → `errors=127`. Assert `rst` mid-round → all outputs are 0 immediately.
